// File: rtl/dmi_sba_preload_seq.sv
// DMI master sequencer: preloads memory sections through System Bus Access, then optionally
// halts the hart, sets its PC via an abstract command and resumes it.
module dmi_sba_preload_seq #(
    parameter int unsigned MaxPolls = 1024,
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                wakeup_en_i,
    input  logic [31:0]         start_pc_i,
    input  logic                sec_valid_i,
    output logic                sec_ready_o,
    input  logic [31:0]         sec_addr_i,
    input  logic [LenWidth-1:0] sec_len_i,
    input  logic                word_valid_i,
    output logic                word_ready_o,
    input  logic [31:0]         word_data_i,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [6:0]          dmi_req_addr_o,
    output logic [1:0]          dmi_req_op_o,
    output logic [31:0]         dmi_req_data_o,
    input  logic                dmi_rsp_valid_i,
    output logic                dmi_rsp_ready_o,
    input  logic [31:0]         dmi_rsp_data_i,
    input  logic [1:0]          dmi_rsp_resp_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);

    localparam int unsigned PollW = $clog2(MaxPolls + 1);

    localparam logic [6:0] AddrDmControl = 7'h10;
    localparam logic [6:0] AddrDmStatus  = 7'h11;
    localparam logic [6:0] AddrData0     = 7'h04;
    localparam logic [6:0] AddrCommand   = 7'h17;
    localparam logic [6:0] AddrSbcs      = 7'h38;
    localparam logic [6:0] AddrSbAddr0   = 7'h39;
    localparam logic [6:0] AddrSbData0   = 7'h3C;

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;

    typedef enum logic [2:0] {StIdle, StReq, StRsp, StSec, StWord} state_e;

    typedef enum logic [3:0] {
        OpAct, OpCfg, OpAddr, OpData, OpFin, OpPc, OpHalt, OpHaltWait,
        OpClr1, OpCmd, OpResume, OpClr2
    } step_e;

    state_e                state_q, state_d;
    step_e                 step_q, step_d;
    logic                  rd_q, rd_d;       // 1: current request is a status read
    logic [PollW-1:0]      poll_q, poll_d;
    logic [LenWidth-1:0]   cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           pc_q, pc_d;
    logic                  wake_q, wake_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [6:0]            step_addr;
    logic [31:0]           step_wdata;
    logic                  step_sbpoll;
    logic                  adv, retry, fail;

    // Write target of each step and whether an SBCS busy poll follows it.
    always_comb begin
        step_addr   = AddrDmControl;
        step_wdata  = 32'h0;
        step_sbpoll = 1'b1;
        unique case (step_q)
            OpAct:      step_wdata = 32'h0000_0001;
            OpCfg:      begin step_addr = AddrSbcs;    step_wdata = 32'h0005_8000; end
            OpAddr:     begin step_addr = AddrSbAddr0; step_wdata = addr_q;        end
            OpData:     begin step_addr = AddrSbData0; step_wdata = word_q;        end
            OpFin:      begin
                step_addr   = AddrSbcs;
                step_wdata  = 32'h0005_0000;
                step_sbpoll = 1'b0;
            end
            OpPc:       begin step_addr = AddrData0;   step_wdata = pc_q;          end
            OpHalt:     step_wdata = 32'h8000_0001;
            OpHaltWait: begin step_addr = AddrDmStatus; step_sbpoll = 1'b0;        end
            OpClr1:     step_wdata = 32'h0000_0001;
            OpCmd:      begin step_addr = AddrCommand; step_wdata = 32'h0023_07B1; end
            OpResume:   step_wdata = 32'h4000_0001;
            OpClr2:     step_wdata = 32'h0000_0001;
            default:    ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rd_d    = rd_q;
        poll_d  = poll_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        pc_d    = pc_q;
        wake_d  = wake_q;
        done_d  = done_q;
        error_d = error_q;

        sec_ready_o     = 1'b0;
        word_ready_o    = 1'b0;
        dmi_req_valid_o = 1'b0;
        dmi_req_addr_o  = 7'h00;
        dmi_req_op_o    = 2'd0;
        dmi_req_data_o  = 32'h0;
        dmi_rsp_ready_o = 1'b0;

        adv   = 1'b0;
        retry = 1'b0;
        fail  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    wake_d  = wakeup_en_i;
                    pc_d    = start_pc_i;
                    step_d  = OpAct;
                    rd_d    = 1'b0;
                    poll_d  = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                dmi_req_valid_o = 1'b1;
                if (rd_q) begin
                    dmi_req_op_o   = OpRead;
                    dmi_req_addr_o = (step_q == OpHaltWait) ? AddrDmStatus : AddrSbcs;
                end else begin
                    dmi_req_op_o   = OpWrite;
                    dmi_req_addr_o = step_addr;
                    dmi_req_data_o = step_wdata;
                end
                if (dmi_req_ready_i) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                dmi_rsp_ready_o = 1'b1;
                if (dmi_rsp_valid_i) begin
                    if (dmi_rsp_resp_i != 2'd0) begin
                        fail = 1'b1;
                    end else if (!rd_q) begin
                        if (step_sbpoll) begin
                            rd_d    = 1'b1;
                            poll_d  = '0;
                            state_d = StReq;
                        end else begin
                            adv = 1'b1;
                        end
                    end else if (step_q == OpHaltWait) begin
                        if (dmi_rsp_data_i[8]) adv = 1'b1;
                        else                   retry = 1'b1;
                    end else if (dmi_rsp_data_i[14:12] != 3'b000) begin
                        fail = 1'b1;
                    end else if (dmi_rsp_data_i[21]) begin
                        retry = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            StSec: begin
                sec_ready_o = 1'b1;
                if (sec_valid_i) begin
                    rd_d    = 1'b0;
                    state_d = StReq;
                    if (sec_len_i == '0) begin
                        step_d = OpFin;
                    end else begin
                        step_d = OpAddr;
                        addr_d = sec_addr_i;
                        cnt_d  = sec_len_i;
                    end
                end
            end
            StWord: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    word_d  = word_data_i;
                    step_d  = OpData;
                    rd_d    = 1'b0;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (adv) begin
            rd_d    = 1'b0;
            poll_d  = '0;
            state_d = StReq;
            unique case (step_q)
                OpAct:      step_d = OpCfg;
                OpCfg:      state_d = StSec;
                OpAddr:     state_d = StWord;
                OpData: begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == LenWidth'(1)) ? StSec : StWord;
                end
                OpFin: begin
                    if (wake_q) begin
                        step_d = OpPc;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                OpPc:       step_d = OpHalt;
                OpHalt: begin
                    step_d = OpHaltWait;
                    rd_d   = 1'b1;
                end
                OpHaltWait: step_d = OpClr1;
                OpClr1:     step_d = OpCmd;
                OpCmd:      step_d = OpResume;
                OpResume:   step_d = OpClr2;
                OpClr2: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: ;
            endcase
        end

        // The read that reaches MaxPolls without success is the last one.
        if (retry) begin
            if (poll_q == PollW'(MaxPolls - 1)) begin
                fail = 1'b1;
            end else begin
                poll_d  = poll_q + 1'b1;
                state_d = StReq;
            end
        end

        if (fail) begin
            error_d = 1'b1;
            done_d  = 1'b0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            step_q  <= OpAct;
            rd_q    <= 1'b0;
            poll_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            word_q  <= 32'h0;
            pc_q    <= 32'h0;
            wake_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rd_q    <= rd_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
            wake_q  <= wake_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_dmi_sba_preload_seq.sv
// Bench for dmi_sba_preload_seq: DMI slave model with busy/halt/fault injection, section and
// word streamers, and a transaction-list reference model built from the preload/wakeup recipe.
module tb_dmi_sba_preload_seq;

    localparam int unsigned MaxPolls = 8;
    localparam int unsigned LenWidth = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic                wakeup_en_i = 1'b0;
    logic [31:0]         start_pc_i = 32'h0;
    logic                sec_valid_i;
    logic                sec_ready_o;
    logic [31:0]         sec_addr_i;
    logic [LenWidth-1:0] sec_len_i;
    logic                word_valid_i;
    logic                word_ready_o;
    logic [31:0]         word_data_i;
    logic                dmi_req_valid_o;
    logic                dmi_req_ready_i;
    logic [6:0]          dmi_req_addr_o;
    logic [1:0]          dmi_req_op_o;
    logic [31:0]         dmi_req_data_o;
    logic                dmi_rsp_valid_i;
    logic                dmi_rsp_ready_o;
    logic [31:0]         dmi_rsp_data_i;
    logic [1:0]          dmi_rsp_resp_i;
    logic                busy_o, done_o, error_o;

    always #5 clk = ~clk;

    dmi_sba_preload_seq #(.MaxPolls(MaxPolls), .LenWidth(LenWidth)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .wakeup_en_i(wakeup_en_i),
        .start_pc_i(start_pc_i), .sec_valid_i(sec_valid_i), .sec_ready_o(sec_ready_o),
        .sec_addr_i(sec_addr_i), .sec_len_i(sec_len_i), .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o), .word_data_i(word_data_i),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
        .dmi_req_data_o(dmi_req_data_o), .dmi_rsp_valid_i(dmi_rsp_valid_i),
        .dmi_rsp_ready_o(dmi_rsp_ready_o), .dmi_rsp_data_i(dmi_rsp_data_i),
        .dmi_rsp_resp_i(dmi_rsp_resp_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic [31:0]         addr;
        logic [LenWidth-1:0] len;
    } sec_t;

    typedef struct {
        bit          wake;
        logic [31:0] pc;
        int          busy;
        int          halt_zero;
        bit          stuck;
        int          err_addr;
        bit          sberr;
        int          stall;
        int          nsec;
        int          len0;
        int          len1;
        bit          exp_done;
        bit          exp_err;
        int          exp_nreq;   // -1: take everything from the reference model
    } vec_t;

    int checks = 0;
    int failures = 0;

    txn_t        act_q[$];
    txn_t        exp_q[$];
    sec_t        sec_hq[$];
    sec_t        sec_list[$];
    logic [31:0] word_q[$];
    logic [31:0] wlist[$];
    int          sec_hs, word_hs;
    int          stable_bad, proto_bad;
    int          halt_left;

    int cfg_busy = 0, cfg_stall = 0, cfg_err_addr = -1;
    bit cfg_stuck = 0, cfg_sberr = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // DMI slave: optional ready stall, one response per request, status per scenario knobs.
    initial begin : dmi_slave
        txn_t        cur;
        int          busy_left;
        logic [31:0] rdata;
        logic [1:0]  resp;
        busy_left = 0;
        dmi_req_ready_i = 1'b0;
        dmi_rsp_valid_i = 1'b0;
        dmi_rsp_data_i  = 32'h0;
        dmi_rsp_resp_i  = 2'd0;
        forever begin
            @(negedge clk);
            if (dmi_req_valid_o === 1'b1) begin
                cur.op   = dmi_req_op_o;
                cur.addr = dmi_req_addr_o;
                cur.data = dmi_req_data_o;
                if (dmi_rsp_ready_o !== 1'b0) proto_bad++;
                for (int k = 0; k < cfg_stall; k++) begin
                    @(negedge clk);
                    if (dmi_req_valid_o !== 1'b1 ||
                        {dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o} !== cur) stable_bad++;
                end
                dmi_req_ready_i = 1'b1;
                @(negedge clk);
                dmi_req_ready_i = 1'b0;
                act_q.push_back(cur);
                rdata = 32'h0;
                resp  = 2'd0;
                if (cur.op == 2'd2) begin
                    busy_left = cfg_busy;
                    if (int'(cur.addr) == cfg_err_addr) resp = 2'd2;
                end else if (cur.addr == 7'h38) begin
                    if (cfg_stuck || busy_left > 0) begin
                        rdata[21] = 1'b1;
                        if (busy_left > 0) busy_left--;
                    end
                    if (cfg_sberr) rdata[14:12] = 3'b010;
                end else if (cur.addr == 7'h11) begin
                    if (halt_left > 0) halt_left--;
                    else rdata[8] = 1'b1;
                end
                dmi_rsp_valid_i = 1'b1;
                dmi_rsp_data_i  = rdata;
                dmi_rsp_resp_i  = resp;
                if (dmi_rsp_ready_o !== 1'b1 || dmi_req_valid_o !== 1'b0) proto_bad++;
                @(negedge clk);
                dmi_rsp_valid_i = 1'b0;
                dmi_rsp_data_i  = 32'h0;
                dmi_rsp_resp_i  = 2'd0;
            end
        end
    end

    initial begin : sec_feed
        sec_valid_i = 1'b0;
        sec_addr_i  = 32'h0;
        sec_len_i   = '0;
        forever begin
            @(negedge clk);
            sec_valid_i = (sec_hq.size() != 0);
            if (sec_valid_i) begin
                sec_addr_i = sec_hq[0].addr;
                sec_len_i  = sec_hq[0].len;
            end
            if (sec_valid_i && sec_ready_o) begin
                void'(sec_hq.pop_front());
                sec_hs++;
            end
        end
    end

    // Words are offered as early as possible so they must wait for the address phase.
    initial begin : word_feed
        word_valid_i = 1'b0;
        word_data_i  = 32'h0;
        forever begin
            @(negedge clk);
            word_valid_i = (word_q.size() != 0);
            if (word_valid_i) word_data_i = word_q[0];
            if (word_valid_i && word_ready_o) begin
                void'(word_q.pop_front());
                word_hs++;
            end
        end
    end

    // Reference model: the expected DMI transaction list for a scenario.
    bit   m_stop;
    vec_t m_v;

    function automatic void m_push(input logic [1:0] op, input logic [6:0] a,
                                   input logic [31:0] d);
        txn_t t;
        t.op = op;
        t.addr = a;
        t.data = d;
        if (!m_stop) exp_q.push_back(t);
    endfunction

    function automatic void m_poll_sb();
        if (m_stop) return;
        if (m_v.sberr) begin
            m_push(2'd1, 7'h38, 32'h0);
            m_stop = 1;
        end else if (m_v.stuck) begin
            for (int i = 0; i < int'(MaxPolls); i++) m_push(2'd1, 7'h38, 32'h0);
            m_stop = 1;
        end else begin
            for (int i = 0; i <= m_v.busy; i++) m_push(2'd1, 7'h38, 32'h0);
        end
    endfunction

    function automatic void m_write(input logic [6:0] a, input logic [31:0] d, input bit poll);
        if (m_stop) return;
        m_push(2'd2, a, d);
        if (int'(a) == m_v.err_addr) begin
            m_stop = 1;
            return;
        end
        if (poll) m_poll_sb();
    endfunction

    function automatic void model_run(input vec_t v);
        int wi;
        m_v = v;
        m_stop = 0;
        exp_q.delete();
        wi = 0;
        m_write(7'h10, 32'h1, 1);
        m_write(7'h38, 32'h0005_8000, 1);
        foreach (sec_list[s]) begin
            m_write(7'h39, sec_list[s].addr, 1);
            for (int w = 0; w < int'(sec_list[s].len); w++) begin
                m_write(7'h3C, wlist[wi], 1);
                wi++;
            end
        end
        m_write(7'h38, 32'h0005_0000, 0);
        if (v.wake) begin
            m_write(7'h04, v.pc, 1);
            m_write(7'h10, 32'h8000_0001, 1);
            for (int i = 0; i <= v.halt_zero; i++) m_push(2'd1, 7'h11, 32'h0);
            m_write(7'h10, 32'h1, 1);
            m_write(7'h17, 32'h0023_07B1, 1);
            m_write(7'h10, 32'h4000_0001, 1);
            m_write(7'h10, 32'h1, 1);
        end
    endfunction

    task automatic prep(input vec_t v);
        sec_t s;
        cfg_busy     = v.busy;
        cfg_stall    = v.stall;
        cfg_err_addr = v.err_addr;
        cfg_stuck    = v.stuck;
        cfg_sberr    = v.sberr;
        halt_left    = v.halt_zero;
        proto_bad    = 0;
        stable_bad   = 0;
        sec_hs       = 0;
        word_hs      = 0;
        act_q.delete();
        sec_list.delete();
        wlist.delete();
        for (int i = 0; i < v.nsec; i++) begin
            s.addr = (i == 0) ? 32'h1000_0000 : 32'h2000_0040;
            s.len  = LenWidth'((i == 0) ? v.len0 : v.len1);
            sec_list.push_back(s);
            for (int w = 0; w < int'(s.len); w++) wlist.push_back($urandom);
        end
        sec_hq = sec_list;
        s.addr = 32'h0;
        s.len  = '0;
        sec_hq.push_back(s);
        word_q = wlist;
        model_run(v);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int   cyc;
        bit   seq_ok;
        int   exp_n;
        bit   exp_d, exp_e;
        prep(v);
        exp_n = (v.exp_nreq < 0) ? exp_q.size() : v.exp_nreq;
        exp_d = (v.exp_nreq < 0) ? !m_stop : v.exp_done;
        exp_e = (v.exp_nreq < 0) ? m_stop : v.exp_err;
        @(negedge clk);
        wakeup_en_i = v.wake;
        start_pc_i  = v.pc;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({name, " start busy/done/error"}, {61'd0, busy_o, done_o, error_o}, 64'b100);
        repeat (3) @(negedge clk);
        if (busy_o === 1'b1) begin
            wakeup_en_i = ~v.wake;
            start_pc_i  = ~v.pc;
            start_i     = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        cyc = 0;
        while (!(done_o === 1'b1 || error_o === 1'b1) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " finished in budget"}, 64'(cyc < 20000), 64'd1);
        repeat (20) @(negedge clk);
        chk({name, " done/error/busy"}, {61'd0, done_o, error_o, busy_o},
            {61'd0, exp_d, exp_e, 1'b0});
        chk({name, " request count"}, 64'(act_q.size()), 64'(exp_n));
        seq_ok = (act_q.size() == exp_q.size());
        checks++;
        foreach (act_q[i]) begin
            if (seq_ok && act_q[i] !== exp_q[i]) begin
                seq_ok = 0;
                $display("FAIL %s sequence at txn %0d: got op=%0d addr=0x%0h data=0x%0h expected op=%0d addr=0x%0h data=0x%0h",
                         name, i, act_q[i].op, act_q[i].addr, act_q[i].data,
                         exp_q[i].op, exp_q[i].addr, exp_q[i].data);
            end
        end
        if (!seq_ok) begin
            failures++;
            if (act_q.size() != exp_q.size())
                $display("FAIL %s sequence length: got %0d expected %0d", name, act_q.size(),
                         exp_q.size());
        end
        chk({name, " req stable while stalled"}, 64'(stable_bad), 64'd0);
        chk({name, " rsp_ready/req timing"}, 64'(proto_bad), 64'd0);
        if (exp_d) begin
            chk({name, " words taken"}, 64'(word_hs), 64'(wlist.size()));
            chk({name, " headers taken"}, 64'(sec_hs), 64'(v.nsec + 1));
        end
        sec_hq.delete();
        word_q.delete();
        repeat (3) @(negedge clk);
    endtask

    function automatic vec_t mk(input bit wake, input logic [31:0] pc, input int busy,
                                input int hz, input bit stuck, input int err_addr,
                                input bit sberr, input int stall, input int nsec,
                                input int len0, input int len1, input bit exp_done,
                                input bit exp_err, input int exp_nreq);
        vec_t v;
        v.wake = wake;   v.pc = pc;         v.busy = busy;   v.halt_zero = hz;
        v.stuck = stuck; v.err_addr = err_addr; v.sberr = sberr; v.stall = stall;
        v.nsec = nsec;   v.len0 = len0;     v.len1 = len1;
        v.exp_done = exp_done; v.exp_err = exp_err; v.exp_nreq = exp_nreq;
        return v;
    endfunction

    vec_t  tbl[8];
    string tname[8];

    initial begin : main
        vec_t v;
        int   cyc;
        tbl[0] = mk(0, 32'h0,         0, 0, 0, -1,    0, 0, 1, 2,  0, 1, 0, 11);
        tname[0] = "one_sec_len2";
        tbl[1] = mk(0, 32'h0,         3, 0, 0, -1,    0, 0, 1, 2,  0, 1, 0, 26);
        tname[1] = "busy3_polls";
        tbl[2] = mk(1, 32'h8000_0000, 0, 1, 0, -1,    0, 0, 1, 1,  0, 1, 0, 23);
        tname[2] = "wakeup";
        tbl[3] = mk(0, 32'h0,         0, 0, 1, -1,    0, 0, 1, 2,  0, 0, 1, 9);
        tname[3] = "sbbusy_stuck";
        tbl[4] = mk(0, 32'h0,         0, 0, 0, 'h3C,  0, 5, 1, 2,  0, 0, 1, 7);
        tname[4] = "stall_resp_err";
        tbl[5] = mk(0, 32'h0,         0, 0, 0, -1,    1, 0, 1, 2,  0, 0, 1, 2);
        tname[5] = "sberror";
        tbl[6] = mk(0, 32'h0,         1, 0, 0, -1,    0, 0, 1, 15, 0, 1, 0, 55);
        tname[6] = "len_max";
        tbl[7] = mk(0, 32'h0,         0, 0, 0, -1,    0, 0, 0, 0,  0, 1, 0, 5);
        tname[7] = "empty_image";

        repeat (3) @(negedge clk);
        chk("in reset outputs", {57'd0, busy_o, done_o, error_o, dmi_req_valid_o,
            dmi_rsp_ready_o, sec_ready_o, word_ready_o}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after reset outputs", {57'd0, busy_o, done_o, error_o, dmi_req_valid_o,
            dmi_rsp_ready_o, sec_ready_o, word_ready_o}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(tname[i], tbl[i]);

        // Asynchronous reset in the middle of a section.
        v = tbl[0];
        v.len0 = 3;
        prep(v);
        @(negedge clk);
        wakeup_en_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (word_hs < 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reset reached section", 64'(word_hs >= 1), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sec_hq.delete();
        word_q.delete();
        #1;
        chk("mid_reset async outputs", {57'd0, busy_o, done_o, error_o, dmi_req_valid_o,
            dmi_rsp_ready_o, sec_ready_o, word_ready_o}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_vec("after_reset_rerun", tbl[0]);

        for (int r = 0; r < 16; r++) begin
            v = mk($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, -1, 0,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 15)), int'($urandom_range(1, 15)), 0, 0, -1);
            run_vec($sformatf("rand%0d", r), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
